fpmul_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one fpmultiplier instance between N requesters.
- The multiplier has no start input. It free-runs out of reset and loads both operands serially over its single 32-bit input.
- This block holds the multiplier in reset while idle, releases it per job, and drives op_a then op_b in the exact load cycles.
- It captures the product when the multiplier's ready rises and returns it, tagged with the requester id. A watchdog aborts hung jobs.

---
 rtl/fpmul_arbiter_if.sv | 26 ++
 rtl/fpmul_arbiter.sv | 153 +++++++++++++++
 tb/tb_fpmul_arbiter.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpmul_arbiter_if.sv
// Requester-side bundle of the fpmul arbiter: job request channel and tagged result pulse.
// The requester (master) drives operands and valid; the arbiter (slave) grants and responds.
interface fpmul_arbiter_if #(
    parameter int N = 4
);
    localparam int IDW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*32-1:0] req_a;
    logic [N*32-1:0] req_b;
    logic            rsp_valid;
    logic [IDW-1:0]  rsp_id;
    logic [31:0]     rsp_product;
    logic            rsp_error;

    modport master (
        output req_valid, req_a, req_b,
        input  req_ready, rsp_valid, rsp_id, rsp_product, rsp_error
    );

    modport slave (
        input  req_valid, req_a, req_b,
        output req_ready, rsp_valid, rsp_id, rsp_product, rsp_error
    );
endinterface

// File: rtl/fpmul_arbiter.sv
// Round-robin arbiter time-sharing one serial-load fpmultiplier across N requesters.
// Grant to rsp_valid in 8 cycles (7 for special operands); one job in flight, req_ready only in IDLE.
module fpmul_arbiter #(
    parameter int N       = 4,
    parameter int TIMEOUT = 15
) (
    input  logic           clock,
    input  logic           nreset,
    fpmul_arbiter_if.slave bus,
    output logic           busy,
    output logic           mul_nreset,
    output logic [31:0]    mul_a,
    input  logic [31:0]    mul_product,
    input  logic           mul_ready
);
    localparam int          IDW             = (N > 1) ? $clog2(N) : 1;
    localparam logic [31:0] TIMEOUT_PRODUCT = 32'h7F800001;

    typedef enum logic [2:0] {
        IDLE,
        RELEASE,
        LOAD_A,
        LOAD_B,
        WAIT,
        DONE
    } state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] job_id_q, job_id_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic [31:0]    op_a_q, op_a_d;
    logic [31:0]    op_b_q, op_b_d;
    logic [31:0]    rsp_product_q, rsp_product_d;
    logic           rsp_error_q, rsp_error_d;
    logic [7:0]     cnt_q, cnt_d;
    logic           mul_nreset_q, mul_nreset_d;
    logic [31:0]    mul_a_q, mul_a_d;

    logic           found;
    logic [IDW-1:0] winner;
    logic [N-1:0]   grant;

    // First valid requester after the last winner, wrapping modulo N.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = 1; k <= N; k++) begin
            if (!found && bus.req_valid[(int'(ptr_q) + k) % N]) begin
                found  = 1'b1;
                winner = IDW'((int'(ptr_q) + k) % N);
            end
        end
    end

    always_comb begin
        grant = '0;
        if (nreset && state_q == IDLE && found) begin
            grant[winner] = 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        job_id_d      = job_id_q;
        rsp_id_d      = rsp_id_q;
        op_a_d        = op_a_q;
        op_b_d        = op_b_q;
        rsp_product_d = rsp_product_q;
        rsp_error_d   = rsp_error_q;
        cnt_d         = cnt_q;

        case (state_q)
            IDLE: begin
                if (|grant) begin
                    op_a_d   = bus.req_a[32*int'(winner) +: 32];
                    op_b_d   = bus.req_b[32*int'(winner) +: 32];
                    job_id_d = winner;
                    ptr_d    = winner;
                    state_d  = RELEASE;
                end
            end
            RELEASE: state_d = LOAD_A;
            LOAD_A:  state_d = LOAD_B;
            LOAD_B: begin
                cnt_d   = 8'd1;
                state_d = WAIT;
            end
            WAIT: begin
                // A product arriving on the last allowed cycle still wins over the abort.
                if (mul_ready) begin
                    rsp_product_d = mul_product;
                    rsp_error_d   = 1'b0;
                    rsp_id_d      = job_id_q;
                    state_d       = DONE;
                end else if (cnt_q == 8'(TIMEOUT)) begin
                    rsp_product_d = TIMEOUT_PRODUCT;
                    rsp_error_d   = 1'b1;
                    rsp_id_d      = job_id_q;
                    state_d       = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Multiplier controls are registered from the next state, never from req_*.
        mul_nreset_d = (state_d == RELEASE) || (state_d == LOAD_A) ||
                       (state_d == LOAD_B)  || (state_d == WAIT);
        mul_a_d      = (state_d == LOAD_A) ? op_a_q :
                       (state_d == LOAD_B) ? op_b_q : 32'h0;
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_q       <= IDLE;
            ptr_q         <= IDW'(N - 1);
            job_id_q      <= '0;
            rsp_id_q      <= '0;
            op_a_q        <= '0;
            op_b_q        <= '0;
            rsp_product_q <= '0;
            rsp_error_q   <= 1'b0;
            cnt_q         <= '0;
            mul_nreset_q  <= 1'b0;
            mul_a_q       <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            job_id_q      <= job_id_d;
            rsp_id_q      <= rsp_id_d;
            op_a_q        <= op_a_d;
            op_b_q        <= op_b_d;
            rsp_product_q <= rsp_product_d;
            rsp_error_q   <= rsp_error_d;
            cnt_q         <= cnt_d;
            mul_nreset_q  <= mul_nreset_d;
            mul_a_q       <= mul_a_d;
        end
    end

    assign bus.req_ready   = grant;
    assign bus.rsp_valid   = (state_q == DONE);
    assign bus.rsp_id      = rsp_id_q;
    assign bus.rsp_product = rsp_product_q;
    assign bus.rsp_error   = rsp_error_q;
    assign busy            = (state_q != IDLE);
    assign mul_nreset      = mul_nreset_q;
    assign mul_a           = mul_a_q;
endmodule

// File: tb/tb_fpmul_arbiter.sv
// Bench for fpmul_arbiter: serial-load multiplier stub, transaction-level arbiter model
// checked every cycle, plus directed jobs with hand-computed results and latencies.
module tb_fpmul_arbiter;
    localparam int N       = 4;
    localparam int TIMEOUT = 15;

    logic        clock;
    logic        nreset;
    logic        busy;
    logic        mul_nreset;
    logic [31:0] mul_a;
    logic [31:0] mul_product;
    logic        mul_ready;
    bit          hang;

    fpmul_arbiter_if #(.N(N)) bus ();

    fpmul_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
        .clock       (clock),
        .nreset      (nreset),
        .bus         (bus),
        .busy        (busy),
        .mul_nreset  (mul_nreset),
        .mul_a       (mul_a),
        .mul_product (mul_product),
        .mul_ready   (mul_ready)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic bit is_special(input logic [31:0] a, input logic [31:0] b);
        return (a[30:23] == 8'h00) || (a[30:23] == 8'hFF) ||
               (b[30:23] == 8'h00) || (b[30:23] == 8'hFF);
    endfunction

    // Truncating single-precision multiply; enough for exactly representable test products.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] p;
        logic [9:0]  e;
        logic        s;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'h00 || b[30:23] == 8'h00) return {s, 31'h0};
        if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return 32'h7FC00000;
        p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = 10'(a[30:23]) + 10'(b[30:23]) - 10'd127;
        if (p[47]) return {s, 8'(e + 10'd1), p[46:24]};
        return {s, 8'(e), p[45:23]};
    endfunction

    // Multiplier stub: leaves reset into start, samples operands in steps 1 and 2,
    // ready after check/regular/carries/final (carries skipped on special operands).
    int          mk = 0;
    logic [31:0] sa = '0;
    logic [31:0] sb = '0;
    always @(posedge clock) begin
        if (!mul_nreset) mk <= 0;
        else begin
            mk <= mk + 1;
            if (mk == 1) sa <= mul_a;
            if (mk == 2) sb <= mul_a;
        end
    end
    assign mul_ready   = mul_nreset && !hang && (mk >= (is_special(sa, sb) ? 5 : 6));
    assign mul_product = mul_ready ? fmul(sa, sb) : 32'h0;

    // Transaction-level model: one job in flight, response at a fixed offset from grant.
    int          m_ptr = N - 1;
    bit          m_active = 0;
    int          m_g, m_rsp_at, m_id, w, win;
    bit          m_hang, fnd;
    logic [31:0] m_a, m_b;
    logic [31:0] m_last_id = '0, m_last_prod = '0, m_last_err = '0;
    logic [N-1:0] exp_ready;
    logic        exp_rv, exp_mnr;
    logic [31:0] exp_mula;

    initial begin
        forever begin
            @(negedge clock);
            if (!nreset) begin
                chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
                chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
                chk("rst_rsp_id", 32'(bus.rsp_id), 32'h0);
                chk("rst_rsp_product", bus.rsp_product, 32'h0);
                chk("rst_rsp_error", 32'(bus.rsp_error), 32'h0);
                chk("rst_busy", 32'(busy), 32'h0);
                chk("rst_mul_nreset", 32'(mul_nreset), 32'h0);
                chk("rst_mul_a", mul_a, 32'h0);
                m_ptr = N - 1; m_active = 0;
                m_last_id = '0; m_last_prod = '0; m_last_err = '0;
            end else begin
                exp_ready = '0;
                fnd = 0; win = 0;
                if (!m_active) begin
                    for (int k = 1; k <= N; k++) begin
                        w = (m_ptr + k) % N;
                        if (!fnd && bus.req_valid[w]) begin
                            fnd = 1; win = w; exp_ready[w] = 1'b1;
                        end
                    end
                end
                exp_rv = m_active && (cyc == m_rsp_at);
                if (exp_rv) begin
                    m_last_id   = 32'(m_id);
                    m_last_prod = m_hang ? 32'h7F800001 : fmul(m_a, m_b);
                    m_last_err  = 32'(m_hang);
                end
                exp_mnr  = m_active && (cyc > m_g) && (cyc < m_rsp_at);
                exp_mula = (m_active && cyc == m_g + 2) ? m_a :
                           (m_active && cyc == m_g + 3) ? m_b : 32'h0;
                chk("req_ready", 32'(bus.req_ready), 32'(exp_ready));
                chk("busy", 32'(busy), 32'(m_active));
                chk("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rv));
                chk("rsp_id", 32'(bus.rsp_id), m_last_id);
                chk("rsp_product", bus.rsp_product, m_last_prod);
                chk("rsp_error", 32'(bus.rsp_error), m_last_err);
                chk("mul_nreset", 32'(mul_nreset), 32'(exp_mnr));
                chk("mul_a", mul_a, exp_mula);
                if (exp_rv) m_active = 0;
                if (fnd) begin
                    m_active = 1; m_g = cyc; m_id = win; m_ptr = win; m_hang = hang;
                    m_a = bus.req_a[32*win +: 32];
                    m_b = bus.req_b[32*win +: 32];
                    m_rsp_at = cyc + (hang ? TIMEOUT + 4 : (is_special(m_a, m_b) ? 7 : 8));
                end
            end
        end
    end

    int          gq[$];
    int          gc[$];
    int          rc[$];
    int          ri[$];
    logic [31:0] rp[$];
    logic        re[$];

    task automatic run(input logic [N-1:0] mask, input bit hold, input int ng, input int nr);
        logic [N-1:0] xfer;
        gq.delete(); gc.delete(); rc.delete(); ri.delete(); rp.delete(); re.delete();
        bus.req_valid = mask;
        for (int t = 0; t < 200 && (gq.size() < ng || rc.size() < nr); t++) begin
            @(negedge clock);
            xfer = bus.req_valid & bus.req_ready;
            for (int i = 0; i < N; i++) begin
                if (xfer[i]) begin gq.push_back(i); gc.push_back(cyc); end
            end
            if (bus.rsp_valid) begin
                rc.push_back(cyc); ri.push_back(int'(bus.rsp_id));
                rp.push_back(bus.rsp_product); re.push_back(bus.rsp_error);
            end
            @(posedge clock); #1;
            if (hold) begin
                if (gq.size() >= ng) bus.req_valid = '0;
            end else begin
                bus.req_valid = bus.req_valid & ~xfer;
            end
        end
        checks++;
        if (gq.size() < ng || rc.size() < nr) begin
            failures++;
            $display("FAIL run_timeout: grants %0d of %0d, responses %0d of %0d",
                     gq.size(), ng, rc.size(), nr);
        end
        bus.req_valid = '0;
    endtask

    task automatic pulse_reset(input int n);
        nreset = 1'b0;
        repeat (n) @(posedge clock);
        #1 nreset = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        nreset = 1'b0; hang = 0;
        bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0;
        repeat (3) @(posedge clock);
        #1 nreset = 1'b1;
        @(posedge clock); #1;

        // 2.0 * 3.0 from requester 0
        bus.req_a[31:0] = 32'h40000000; bus.req_b[31:0] = 32'h40400000;
        run(4'b0001, 0, 1, 1);
        chk("t1_grant_id", 32'(gq[0]), 32'd0);
        chk("t1_latency", 32'(rc[0] - gc[0]), 32'd8);
        chk("t1_rsp_id", 32'(ri[0]), 32'd0);
        chk("t1_product", rp[0], 32'h40C00000);
        chk("t1_error", 32'(re[0]), 32'd0);
        repeat (2) @(posedge clock); #1;

        // zero operand takes the short path
        bus.req_a[95:64] = 32'h00000000; bus.req_b[95:64] = 32'h3F800000;
        run(4'b0100, 0, 1, 1);
        chk("t2_grant_id", 32'(gq[0]), 32'd2);
        chk("t2_latency", 32'(rc[0] - gc[0]), 32'd7);
        chk("t2_product", rp[0], 32'h00000000);
        chk("t2_error", 32'(re[0]), 32'd0);

        // all four held from reset: grants 0,1,2,3,0 every 9 cycles
        pulse_reset(2);
        for (int i = 0; i < N; i++) bus.req_b[32*i +: 32] = 32'h3FC00000;
        bus.req_a[31:0]   = 32'h3F800000;
        bus.req_a[63:32]  = 32'h40000000;
        bus.req_a[95:64]  = 32'h40400000;
        bus.req_a[127:96] = 32'h40800000;
        run(4'b1111, 1, 5, 5);
        begin
            int          exp_ids[5]  = '{0, 1, 2, 3, 0};
            logic [31:0] exp_prod[5] = '{32'h3FC00000, 32'h40400000, 32'h40900000,
                                         32'h40C00000, 32'h3FC00000};
            for (int j = 0; j < 5; j++) begin
                chk("t3_grant_order", 32'(gq[j]), 32'(exp_ids[j]));
                chk("t3_rsp_id", 32'(ri[j]), 32'(exp_ids[j]));
                chk("t3_product", rp[j], exp_prod[j]);
            end
            for (int j = 1; j < 5; j++) chk("t3_rsp_spacing", 32'(rc[j] - rc[j-1]), 32'd9);
        end

        // hung multiplier: watchdog abort
        bus.req_a[127:96] = 32'h40000000; bus.req_b[127:96] = 32'h40400000;
        hang = 1;
        run(4'b1000, 0, 1, 1);
        hang = 0;
        chk("t4_latency", 32'(rc[0] - gc[0]), 32'd19);
        chk("t4_rsp_id", 32'(ri[0]), 32'd3);
        chk("t4_product", rp[0], 32'h7F800001);
        chk("t4_error", 32'(re[0]), 32'd1);

        // reset during WAIT drops the job; requester 0 then wins
        run(4'b0010, 0, 1, 0);
        repeat (5) @(posedge clock);
        #1 pulse_reset(2);
        run(4'b0101, 0, 2, 2);
        chk("t5_first_grant", 32'(gq[0]), 32'd0);
        chk("t5_second_grant", 32'(gq[1]), 32'd2);
        chk("t5_first_rsp_id", 32'(ri[0]), 32'd0);
        chk("t5_first_product", rp[0], 32'h3FC00000);
        chk("t5_second_product", rp[1], 32'h40900000);

        // pointer at 1: requester 3 beats 1
        run(4'b0010, 0, 1, 1);
        run(4'b1010, 0, 2, 2);
        chk("t6_first_grant", 32'(gq[0]), 32'd3);
        chk("t6_second_grant", 32'(gq[1]), 32'd1);
        chk("t6_rsp_id0", 32'(ri[0]), 32'd3);
        chk("t6_rsp_id1", 32'(ri[1]), 32'd1);
        chk("t6_product0", rp[0], 32'h40C00000);

        repeat (3) @(posedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
